// File: rtl/arm_decode_stage_if.sv
// Fetch-to-decode bundle: instruction and handshake in, registered decode fields and controls out.
// The master side drives the instruction; the slave side is the decode stage.
interface arm_decode_stage_if #(parameter int INSTR_W = 32);
  logic [INSTR_W-1:0] Instruction;
  logic               valid_in;
  logic               stall;
  logic               flush;
  logic [3:0]         cond_d;
  logic [1:0]         op_d;
  logic [3:0]         cmd_d;
  logic [3:0]         rn_d;
  logic [3:0]         rd_d;
  logic [3:0]         rm_d;
  logic [11:0]        src2_d;
  logic               imm_en_d;
  logic               set_flags_d;
  logic               reg_write_d;
  logic               mem_write_d;
  logic               mem_to_reg_d;
  logic               branch_d;
  logic               valid_out;
  logic               hazard_stall;

  modport master (
    output Instruction, valid_in, stall, flush,
    input  cond_d, op_d, cmd_d, rn_d, rd_d, rm_d, src2_d, imm_en_d, set_flags_d,
           reg_write_d, mem_write_d, mem_to_reg_d, branch_d, valid_out, hazard_stall
  );

  modport slave (
    input  Instruction, valid_in, stall, flush,
    output cond_d, op_d, cmd_d, rn_d, rd_d, rm_d, src2_d, imm_en_d, set_flags_d,
           reg_write_d, mem_write_d, mem_to_reg_d, branch_d, valid_out, hazard_stall
  );
endinterface

// File: rtl/arm_decode_stage.sv
// ARM decode pipeline register with optional load-use bubble insertion.
// Define DECODE_HAZARD_EN to enable load-use detection, the BUBBLE state and hazard_stall.
module arm_decode_stage #(
  parameter int INSTR_W = 32
) (
  input logic               clk,
  input logic               reset,
  arm_decode_stage_if.slave bus
);

  typedef enum logic {RUN, BUBBLE} state_e;

  typedef struct packed {
    logic [3:0]  cond;
    logic [1:0]  op;
    logic [3:0]  cmd;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [11:0] src2;
    logic        imm_en;
    logic        set_flags;
    logic        reg_write;
    logic        mem_write;
    logic        mem_to_reg;
    logic        branch;
    logic        valid;
  } dec_t;

  // An invalid word or op 11 decodes to an all-zero bubble.
  function automatic dec_t decode(input logic [31:0] ins, input logic v);
    dec_t d;
    d = '0;
    if (v && ins[27:26] != 2'b11) begin
      d.cond      = ins[31:28];
      d.op        = ins[27:26];
      d.imm_en    = ins[25];
      d.cmd       = ins[24:21];
      d.set_flags = ins[20];
      d.rn        = ins[19:16];
      d.rd        = ins[15:12];
      d.src2      = ins[11:0];
      d.valid     = 1'b1;
      case (ins[27:26])
        2'b00:   d.reg_write = (ins[24:23] != 2'b10);
        2'b01: begin
          d.reg_write  = ins[20];
          d.mem_to_reg = ins[20];
          d.mem_write  = ~ins[20];
        end
        default: begin
          d.branch    = 1'b1;
          d.reg_write = ins[24];
        end
      endcase
    end
    return d;
  endfunction

  logic [INSTR_W-1:0] instr;
  state_e             state_q, state_d;
  dec_t               dec_q, dec_d;
  logic               hazard;

  assign instr = bus.Instruction;

  always_comb begin
    hazard  = 1'b0;
    state_d = state_q;
    dec_d   = dec_q;
`ifdef DECODE_HAZARD_EN
    // A registered LDR feeds the incoming rn, or its rm for register-form data ops.
    hazard = (state_q == RUN) && dec_q.valid && dec_q.mem_to_reg && bus.valid_in &&
             !bus.flush && !bus.stall &&
             ((instr[19:16] == dec_q.rd) ||
              (!instr[25] && instr[27:26] == 2'b00 && instr[3:0] == dec_q.rd));
`endif
    if (bus.flush) begin
      dec_d   = '0;
      state_d = RUN;
    end else if (bus.stall) begin
      dec_d   = dec_q;
      state_d = state_q;
    end else if (hazard) begin
      dec_d   = '0;
      state_d = BUBBLE;
    end else begin
      dec_d   = decode(instr, bus.valid_in);
      state_d = RUN;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      dec_q   <= '0;
    end else begin
      state_q <= state_d;
      dec_q   <= dec_d;
    end
  end

  assign bus.cond_d       = dec_q.cond;
  assign bus.op_d         = dec_q.op;
  assign bus.cmd_d        = dec_q.cmd;
  assign bus.rn_d         = dec_q.rn;
  assign bus.rd_d         = dec_q.rd;
  assign bus.rm_d         = dec_q.src2[3:0];
  assign bus.src2_d       = dec_q.src2;
  assign bus.imm_en_d     = dec_q.imm_en;
  assign bus.set_flags_d  = dec_q.set_flags;
  assign bus.reg_write_d  = dec_q.reg_write;
  assign bus.mem_write_d  = dec_q.mem_write;
  assign bus.mem_to_reg_d = dec_q.mem_to_reg;
  assign bus.branch_d     = dec_q.branch;
  assign bus.valid_out    = dec_q.valid;
  assign bus.hazard_stall = hazard;

endmodule

// File: tb/tb_arm_decode_stage.sv
// Directed bench for arm_decode_stage; hazard expectations follow DECODE_HAZARD_EN.
module tb_arm_decode_stage;

  localparam logic [31:0] ADD_R0_1   = 32'hE2900001;
  localparam logic [31:0] CMP_R1_0   = 32'hE3510000;
  localparam logic [31:0] BL_0       = 32'hEB000000;
  localparam logic [31:0] B_0        = 32'hEA000000;
  localparam logic [31:0] BAD_OP     = 32'hEC000000;
  localparam logic [31:0] LDR_R7     = 32'hE5937000;
  localparam logic [31:0] LDR_R7_R7  = 32'hE5977000;
  localparam logic [31:0] LDR_R1_7   = 32'hE5931007;
  localparam logic [31:0] LDR_R15    = 32'hE593F000;
  localparam logic [31:0] ADD_R1_R7  = 32'hE2871002;
  localparam logic [31:0] ADD_R1_R15 = 32'hE28F1002;
  localparam logic [31:0] ADD_R2_R57 = 32'hE0852007;
  localparam logic [31:0] STR_R4     = 32'hE5834000;
  localparam logic [31:0] ADD_R1_R4  = 32'hE2841002;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  arm_decode_stage_if bus ();

  arm_decode_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic [31:0] ins, input logic v, input logic st, input logic fl);
    bus.Instruction = ins;
    bus.valid_in    = v;
    bus.stall       = st;
    bus.flush       = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Decode register holds an LDR; present a user and expect one bubble at most.
  task automatic use_after_ldr(input string tag, input logic [31:0] user, input logic [3:0] exp_rd);
    drive(user, 1'b1, 1'b0, 1'b0);
`ifdef DECODE_HAZARD_EN
    chk({tag, "_hz"}, 32'(bus.hazard_stall), 32'd1);
    tick();
    chk({tag, "_bubble"}, 32'(bus.valid_out), 32'd0);
    chk({tag, "_bubble_ctl"}, 32'(bus.reg_write_d), 32'd0);
    chk({tag, "_hz_in_bubble"}, 32'(bus.hazard_stall), 32'd0);
    drive(user, 1'b1, 1'b1, 1'b0);
    tick();
    chk({tag, "_bubble_stall"}, 32'(bus.valid_out), 32'd0);
    drive(user, 1'b1, 1'b0, 1'b0);
    tick();
`else
    chk({tag, "_no_hz"}, 32'(bus.hazard_stall), 32'd0);
    tick();
`endif
    chk({tag, "_valid"}, 32'(bus.valid_out), 32'd1);
    chk({tag, "_rd"}, 32'(bus.rd_d), 32'(exp_rd));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    drive(ADD_R0_1, 1'b1, 1'b0, 1'b0);
    #3;
    chk("rst_valid", 32'(bus.valid_out), 32'd0);
    chk("rst_hz", 32'(bus.hazard_stall), 32'd0);
    chk("rst_reg_write", 32'(bus.reg_write_d), 32'd0);
    tick();
    chk("rst_held", 32'(bus.valid_out), 32'd0);
    reset = 1'b0;

    // first edge after release loads ADD R0,R0,#1
    tick();
    chk("add_valid", 32'(bus.valid_out), 32'd1);
    chk("add_op", 32'(bus.op_d), 32'd0);
    chk("add_cmd", 32'(bus.cmd_d), 32'h4);
    chk("add_imm", 32'(bus.imm_en_d), 32'd1);
    chk("add_rw", 32'(bus.reg_write_d), 32'd1);
    chk("add_rd", 32'(bus.rd_d), 32'd0);
    chk("add_src2", 32'(bus.src2_d), 32'd1);
    chk("add_cond", 32'(bus.cond_d), 32'hE);
    chk("add_s", 32'(bus.set_flags_d), 32'd1);

    drive(CMP_R1_0, 1'b1, 1'b0, 1'b0); tick();
    chk("cmp_rw", 32'(bus.reg_write_d), 32'd0);
    chk("cmp_cmd", 32'(bus.cmd_d), 32'hA);
    drive(BL_0, 1'b1, 1'b0, 1'b0); tick();
    chk("bl_branch", 32'(bus.branch_d), 32'd1);
    chk("bl_rw", 32'(bus.reg_write_d), 32'd1);
    drive(B_0, 1'b1, 1'b0, 1'b0); tick();
    chk("b_branch", 32'(bus.branch_d), 32'd1);
    chk("b_rw", 32'(bus.reg_write_d), 32'd0);
    drive(BAD_OP, 1'b1, 1'b0, 1'b0); tick();
    chk("badop_valid", 32'(bus.valid_out), 32'd0);
    chk("badop_branch", 32'(bus.branch_d), 32'd0);
    chk("badop_op", 32'(bus.op_d), 32'd0);
    drive(ADD_R0_1, 1'b0, 1'b0, 1'b0); tick();
    chk("novalid", 32'(bus.valid_out), 32'd0);

    // load-use on rn
    drive(LDR_R7, 1'b1, 1'b0, 1'b0); tick();
    chk("ldr_mtr", 32'(bus.mem_to_reg_d), 32'd1);
    chk("ldr_rw", 32'(bus.reg_write_d), 32'd1);
    chk("ldr_rd", 32'(bus.rd_d), 32'd7);
    use_after_ldr("ldr_add", ADD_R1_R7, 4'd1);
    chk("ldr_add_rn", 32'(bus.rn_d), 32'd7);

    // stall holds everything and suppresses hazard_stall
    drive(CMP_R1_0, 1'b1, 1'b1, 1'b0); tick();
    chk("stall_rn", 32'(bus.rn_d), 32'd7);
    chk("stall_rw", 32'(bus.reg_write_d), 32'd1);
    chk("stall_hz", 32'(bus.hazard_stall), 32'd0);

    // store never creates a hazard
    drive(STR_R4, 1'b1, 1'b0, 1'b0); tick();
    chk("str_mw", 32'(bus.mem_write_d), 32'd1);
    chk("str_rw", 32'(bus.reg_write_d), 32'd0);
    drive(ADD_R1_R4, 1'b1, 1'b0, 1'b0);
    chk("str_add_hz", 32'(bus.hazard_stall), 32'd0);
    tick();
    chk("str_add_valid", 32'(bus.valid_out), 32'd1);
    chk("str_add_rn", 32'(bus.rn_d), 32'd4);

    // flush in the detecting cycle wins
    drive(LDR_R7, 1'b1, 1'b0, 1'b0); tick();
    drive(ADD_R1_R7, 1'b1, 1'b0, 1'b1);
    chk("flush_hz", 32'(bus.hazard_stall), 32'd0);
    tick();
    chk("flush_bubble", 32'(bus.valid_out), 32'd0);
    drive(ADD_R0_1, 1'b1, 1'b0, 1'b0); tick();
    chk("after_flush_valid", 32'(bus.valid_out), 32'd1);
    drive(CMP_R1_0, 1'b1, 1'b1, 1'b1); tick();
    chk("flush_over_stall", 32'(bus.valid_out), 32'd0);

    // rm path, r15, back-to-back LDRs, and an rm lookalike on a memory op
    drive(LDR_R7, 1'b1, 1'b0, 1'b0); tick();
    use_after_ldr("rm", ADD_R2_R57, 4'd2);
    chk("rm_field", 32'(bus.rm_d), 32'd7);
    drive(LDR_R15, 1'b1, 1'b0, 1'b0); tick();
    use_after_ldr("r15", ADD_R1_R15, 4'd1);
    drive(LDR_R7, 1'b1, 1'b0, 1'b0); tick();
    use_after_ldr("ldr_ldr", LDR_R7_R7, 4'd7);
    use_after_ldr("ldr_ldr_add", ADD_R1_R7, 4'd1);
    drive(LDR_R7, 1'b1, 1'b0, 1'b0); tick();
    drive(LDR_R1_7, 1'b1, 1'b0, 1'b0);
    chk("memop_rm_hz", 32'(bus.hazard_stall), 32'd0);
    tick();
    chk("memop_rm_valid", 32'(bus.valid_out), 32'd1);

    // asynchronous reset mid-cycle (in BUBBLE when hazards are enabled)
    drive(LDR_R7, 1'b1, 1'b0, 1'b0); tick();
    drive(ADD_R1_R7, 1'b1, 1'b0, 1'b0); tick();
    #2 reset = 1'b1;
    #1;
    chk("async_rst_valid", 32'(bus.valid_out), 32'd0);
    chk("async_rst_rd", 32'(bus.rd_d), 32'd0);
    chk("async_rst_rn", 32'(bus.rn_d), 32'd0);
    chk("async_rst_hz", 32'(bus.hazard_stall), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    chk("post_rst_valid", 32'(bus.valid_out), 32'd1);
    chk("post_rst_rd", 32'(bus.rd_d), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/arm_decode_stage.md
ARM_DECODE_STAGE -- requirements
Module: arm_decode_stage

Interface
REQ-001 Parameter: INSTR_W, default 32, instruction width; only 32 is supported.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  reset, asynchronous and active-high.
REQ-004 Port: Instruction  input  32  fetched word, {cond[31:28], op[27:26], I[25], cmd[24:21], S[20], rn[19:16], rd[15:12], src2[11:0]}.
REQ-005 Port: valid_in  input  1  Instruction is valid this cycle.
REQ-006 Port: stall  input  1  downstream hold; decode register keeps its value.
REQ-007 Port: flush  input  1  discard the decode register contents (branch taken).
REQ-008 Port: cond_d, op_d, cmd_d, rn_d, rd_d, rm_d, src2_d  output  4/2/4/4/4/4/12  registered fields; rm_d is src2[3:0].
REQ-009 Port: imm_en_d, set_flags_d  output  1 each  registered I and S bits.
REQ-010 Port: reg_write_d, mem_write_d, mem_to_reg_d, branch_d  output  1 each  registered control signals.
REQ-011 Port: valid_out  output  1  decode register holds a real instruction.
REQ-012 Port: hazard_stall  output  1  fetch holds PC and Instruction this cycle.

Function
REQ-013 The block decodes op 00 as data, 01 as memory, 10 as branch, and 11 as invalid; an invalid op loads as a bubble.
REQ-014 Data: reg_write=1 unless cmd is 1000 to 1011 (compare ops); mem_write=0; mem_to_reg=0.
REQ-015 Memory: S=1 is LDR, giving reg_write=1 and mem_to_reg=1; S=0 is STR, giving mem_write=1.
REQ-016 Branch: branch_d=1; reg_write=1 only when cmd[3]=1 (link).
REQ-017 Latency is exactly one cycle: an instruction accepted at edge N appears on the outputs after edge N.
REQ-018 A bubble forces valid_out=0 and all control outputs to 0; field outputs are don't-care but are driven to 0.
REQ-019 Priority at each edge is flush > stall > hazard > load.
- flush loads a bubble even when stall=1.
- stall=1 with flush=0 holds every output.
REQ-020 State machine, states RUN and BUBBLE; reset enters RUN.
REQ-021 In RUN, a load-use hazard moves to BUBBLE. Hazard condition:
- the registered instruction is valid, LDR, and not flushed;
- the incoming instruction is valid;
- incoming rn equals rd_d, or incoming I=0 and op=00 and src2[3:0] equals rd_d.
REQ-022 Entering BUBBLE loads a bubble, and hazard_stall=1 combinationally during the detecting cycle.
REQ-023 BUBBLE returns to RUN on the next non-stalled edge and loads the held Instruction normally; hazard_stall=0 in BUBBLE.
REQ-024 flush in BUBBLE returns to RUN with a bubble loaded.
REQ-025 stall in BUBBLE holds the state.
REQ-026 hazard_stall is 0 whenever flush=1 or stall=1.
REQ-027 Back-to-back LDRs to the same register produce exactly one bubble per dependent instruction, never two.
REQ-028 Register r15 is treated like any other register in hazard comparison.

Reset
REQ-029 Reset, asserted at any time including mid-BUBBLE, clears all outputs to 0, valid_out=0, hazard_stall=0, and state RUN, immediately and without waiting for clk.
REQ-030 The first load after reset deassertion occurs on the first rising edge with reset=0.

Configuration
REQ-031 With DECODE_HAZARD_EN defined, load-use detection, the BUBBLE state, and hazard_stall operate as specified.
REQ-032 Without DECODE_HAZARD_EN, hazard_stall is tied 0, the FSM stays in RUN, and every valid instruction loads directly.

Verification
REQ-033 reset pulse mid-run -> all outputs 0 asynchronously; valid_out=0 until the first valid load.
REQ-034 ADD R0,R0,#1 (0xE2900001), valid_in=1 -> next cycle op_d=00, cmd_d=0100, imm_en_d=1, reg_write_d=1, rd_d=0, src2_d=1.
REQ-035 LDR R7,[R3] (0xE5937000) then ADD R1,R7,#2 -> hazard_stall=1 for one cycle, one bubble, then ADD appears with rn_d=7.
REQ-036 STR R4,[R3] (0xE5834000) then ADD R1,R4,#2 -> no hazard; mem_write_d=1, then ADD on the next cycle.
REQ-037 LDR R7 then dependent ADD with flush=1 in the detecting cycle -> bubble, hazard_stall=0, state RUN.
REQ-038 DECODE_HAZARD_EN undefined, same sequence as REQ-035 -> no bubble; ADD decoded on the cycle after LDR.
